// File: rtl/exmem_skid_reg_pkg.sv
// Shared types and constants for the EX->MEM skid register.
// Holds the FSM state encoding, load-type codes and the payload width helper.
package exmem_skid_reg_pkg;

  typedef enum logic [1:0] {
    EXMEM_EMPTY = 2'd0,
    EXMEM_ONE   = 2'd1,
    EXMEM_FULL  = 2'd2
  } exmem_state_e;

  localparam logic [2:0] LT_LB   = 3'd0;
  localparam logic [2:0] LT_LH   = 3'd1;
  localparam logic [2:0] LT_LW   = 3'd2;
  localparam logic [2:0] LT_LBU  = 3'd3;
  localparam logic [2:0] LT_LHU  = 3'd4;
  localparam logic [2:0] LT_NONE = 3'd7;

  // alu_out, store_data, pc, rd, reg_write, mem_write[4], load_type[3]
  function automatic int payload_w(input int xlen, input int raw);
    return 3 * xlen + raw + 1 + 4 + 3;
  endfunction

endpackage

// File: rtl/exmem_slot.sv
// One payload entry: load-enabled register with synchronous clear.
module exmem_slot #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         ld,
  input  logic         clr,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  always_ff @(posedge clk) begin
    if (!rst_n || clr) q <= '0;
    else if (ld)       q <= d;
  end

endmodule

// File: rtl/exmem_skid_reg.sv
// Elastic EX->MEM register with a 2-entry skid so ex_ready comes straight from flops.
// Optional counters enabled by defining EXMEM_STAT_EN.
module exmem_skid_reg
  import exmem_skid_reg_pkg::*;
#(
  parameter int XLEN       = 32,
  parameter int REG_ADDR_W = 5
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  flush,
  input  logic                  ex_valid,
  output logic                  ex_ready,
  input  logic [XLEN-1:0]       ex_alu_out,
  input  logic [XLEN-1:0]       ex_store_data,
  input  logic [XLEN-1:0]       ex_pc,
  input  logic [REG_ADDR_W-1:0] ex_rd,
  input  logic                  ex_reg_write,
  input  logic [3:0]            ex_mem_write,
  input  logic [2:0]            ex_load_type,
  output logic                  mem_valid,
  input  logic                  mem_ready,
  output logic [XLEN-1:0]       mem_alu_out,
  output logic [XLEN-1:0]       mem_store_data,
  output logic [XLEN-1:0]       mem_pc,
  output logic [REG_ADDR_W-1:0] mem_rd,
  output logic                  mem_reg_write,
  output logic [3:0]            mem_mem_write,
  output logic [2:0]            mem_load_type
`ifdef EXMEM_STAT_EN
  ,
  output logic [31:0]           stat_stall_cnt,
  output logic [15:0]           stat_flush_cnt
`endif
);

  localparam int PW = payload_w(XLEN, REG_ADDR_W);

  exmem_state_e state, nxt;
  logic          in_fire, out_fire;
  logic          main_ld, main_clr, skid_ld;
  logic [PW-1:0] in_pl, main_d, main_q, skid_q;

  assign in_fire  = ex_valid & ex_ready;
  assign out_fire = mem_valid & mem_ready;

  // Writes to x0 are dropped at capture so MEM/WB never see them.
  assign in_pl = {ex_alu_out, ex_store_data, ex_pc, ex_rd,
                  ex_reg_write & (ex_rd != '0), ex_mem_write, ex_load_type};

  always_comb begin
    nxt      = state;
    main_ld  = 1'b0;
    main_clr = 1'b0;
    skid_ld  = 1'b0;
    main_d   = in_pl;
    case (state)
      EXMEM_EMPTY: if (in_fire) begin
        main_ld = 1'b1;
        nxt     = EXMEM_ONE;
      end
      EXMEM_ONE: begin
        if (in_fire && out_fire) begin
          main_ld = 1'b1;
        end else if (in_fire) begin
          skid_ld = 1'b1;
          nxt     = EXMEM_FULL;
        end else if (out_fire) begin
          main_clr = 1'b1;
          nxt      = EXMEM_EMPTY;
        end
      end
      EXMEM_FULL: if (out_fire) begin
        main_ld = 1'b1;
        main_d  = skid_q;
        nxt     = EXMEM_ONE;
      end
      default: begin
        main_clr = 1'b1;
        nxt      = EXMEM_EMPTY;
      end
    endcase
    // Clearing MAIN keeps mem_* at zero while empty after a flush.
    if (flush) begin
      nxt      = EXMEM_EMPTY;
      main_clr = 1'b1;
      main_ld  = 1'b0;
      skid_ld  = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= EXMEM_EMPTY;
      mem_valid <= 1'b0;
      ex_ready  <= 1'b1;
    end else begin
      state     <= nxt;
      mem_valid <= (nxt != EXMEM_EMPTY);
      ex_ready  <= (nxt != EXMEM_FULL);
    end
  end

  exmem_slot #(.W(PW)) u_main (
    .clk(clk), .rst_n(rst_n), .ld(main_ld), .clr(main_clr), .d(main_d), .q(main_q)
  );

  exmem_slot #(.W(PW)) u_skid (
    .clk(clk), .rst_n(rst_n), .ld(skid_ld), .clr(1'b0), .d(in_pl), .q(skid_q)
  );

  assign {mem_alu_out, mem_store_data, mem_pc, mem_rd,
          mem_reg_write, mem_mem_write, mem_load_type} = main_q;

`ifdef EXMEM_STAT_EN
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stat_stall_cnt <= '0;
      stat_flush_cnt <= '0;
    end else begin
      if (mem_valid && !mem_ready)
        stat_stall_cnt <= stat_stall_cnt + 32'd1;
      if (flush && (state != EXMEM_EMPTY || ex_valid))
        stat_flush_cnt <= stat_flush_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_exmem_skid_reg.sv
// Bench for exmem_skid_reg: FIFO-queue model checked every cycle plus directed literal checks.
// Define EXMEM_STAT_EN to also exercise the statistics counters.
module tb_exmem_skid_reg;

  logic        clk = 1'b0, rst_n = 1'b0, flush = 1'b0;
  logic        ex_valid = 1'b0, mem_ready = 1'b0;
  logic [31:0] ex_alu_out = '0, ex_store_data = '0, ex_pc = '0;
  logic [4:0]  ex_rd = '0;
  logic        ex_reg_write = 1'b0;
  logic [3:0]  ex_mem_write = '0;
  logic [2:0]  ex_load_type = '0;
  logic        ex_ready, mem_valid, mem_reg_write;
  logic [31:0] mem_alu_out, mem_store_data, mem_pc;
  logic [4:0]  mem_rd;
  logic [3:0]  mem_mem_write;
  logic [2:0]  mem_load_type;
`ifdef EXMEM_STAT_EN
  logic [31:0] stat_stall_cnt;
  logic [15:0] stat_flush_cnt;
`endif

  exmem_skid_reg dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .ex_valid(ex_valid), .ex_ready(ex_ready),
    .ex_alu_out(ex_alu_out), .ex_store_data(ex_store_data), .ex_pc(ex_pc),
    .ex_rd(ex_rd), .ex_reg_write(ex_reg_write), .ex_mem_write(ex_mem_write),
    .ex_load_type(ex_load_type),
    .mem_valid(mem_valid), .mem_ready(mem_ready),
    .mem_alu_out(mem_alu_out), .mem_store_data(mem_store_data), .mem_pc(mem_pc),
    .mem_rd(mem_rd), .mem_reg_write(mem_reg_write), .mem_mem_write(mem_mem_write),
    .mem_load_type(mem_load_type)
`ifdef EXMEM_STAT_EN
    , .stat_stall_cnt(stat_stall_cnt), .stat_flush_cnt(stat_flush_cnt)
`endif
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: an in-order queue of at most two entries.
  logic [108:0] q[$];
  logic [108:0] ent;
  bit           zero_req = 1'b0, started = 1'b0, inf, outf;
  int           stall_m = 0, flush_m = 0;

  always @(posedge clk) begin
    if (!rst_n) begin
      q.delete();
      zero_req = 1'b1;
      stall_m  = 0;
      flush_m  = 0;
    end else begin
      inf  = ex_valid && (q.size() < 2);
      outf = (q.size() > 0) && mem_ready;
      ent  = {ex_alu_out, ex_store_data, ex_pc, ex_rd,
              ex_reg_write && (ex_rd != 5'd0), ex_mem_write, ex_load_type};
      if (q.size() > 0 && !mem_ready) stall_m++;
      if (flush && (q.size() > 0 || ex_valid)) flush_m++;
      if (flush) begin
        q.delete();
        zero_req = 1'b1;
      end else begin
        if (outf) void'(q.pop_front());
        if (inf) begin
          q.push_back(ent);
          zero_req = 1'b0;
        end
      end
    end
    started = 1'b1;
  end

  always @(negedge clk) begin
    if (started) begin
      chk("mem_valid", 128'(mem_valid), 128'(q.size() != 0));
      chk("ex_ready", 128'(ex_ready), 128'(q.size() < 2));
      if (q.size() > 0)
        chk("payload", 128'({mem_alu_out, mem_store_data, mem_pc, mem_rd, mem_reg_write,
                             mem_mem_write, mem_load_type}), 128'(q[0]));
      else if (zero_req)
        chk("empty_payload", 128'({mem_alu_out, mem_store_data, mem_pc, mem_rd, mem_reg_write,
                                   mem_mem_write, mem_load_type}), 128'd0);
`ifdef EXMEM_STAT_EN
      chk("stall_cnt_model", 128'(stat_stall_cnt), 128'(stall_m));
      chk("flush_cnt_model", 128'(stat_flush_cnt), 128'(flush_m[15:0]));
`endif
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [31:0] a);
    ex_valid      = 1'b1;
    ex_alu_out    = a;
    ex_store_data = ~a;
    ex_pc         = a << 2;
    ex_rd         = a[4:0];
    ex_reg_write  = 1'b1;
    ex_mem_write  = a[3:0];
    ex_load_type  = a[2:0];
  endtask

  initial begin
    // Reset with ex_valid asserted
    push(32'h55);
    repeat (3) tick();
    chk("rst_mem_valid", 128'(mem_valid), 128'd0);
    chk("rst_alu_out", 128'(mem_alu_out), 128'd0);
    chk("rst_ex_ready", 128'(ex_ready), 128'd1);
    rst_n = 1'b1; ex_valid = 1'b0;
    tick();

    // Streaming, no bubbles
    mem_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      push(32'h100 + i);
      tick();
      chk("stream_valid", 128'(mem_valid), 128'd1);
      chk("stream_alu", 128'(mem_alu_out), 128'(32'h100 + i));
    end
    ex_valid = 1'b0;
    tick();
    chk("stream_drain", 128'(mem_valid), 128'd0);

    // Backpressure
    mem_ready = 1'b0;
    push(32'hA); tick();
    chk("bp_ready1", 128'(ex_ready), 128'd1);
    push(32'hB); tick();
    chk("bp_ready2", 128'(ex_ready), 128'd0);
    push(32'hC); tick();
    chk("bp_hold", 128'(mem_alu_out), 128'hA);
    mem_ready = 1'b1; tick();
    chk("bp_second", 128'(mem_alu_out), 128'hB);
    tick();
    chk("bp_third", 128'(mem_alu_out), 128'hC);
    ex_valid = 1'b0; tick();
    chk("bp_empty", 128'(mem_valid), 128'd0);

    // Flush while full with a simultaneous push
    mem_ready = 1'b0;
    push(32'h1); tick();
    push(32'h2); tick();
    push(32'h3); flush = 1'b1; tick();
    chk("fl_valid", 128'(mem_valid), 128'd0);
    chk("fl_ready", 128'(ex_ready), 128'd1);
    chk("fl_alu", 128'(mem_alu_out), 128'd0);
    flush = 1'b0; ex_valid = 1'b0; tick();
    chk("fl_no3", 128'(mem_valid), 128'd0);

    // x0 writeback suppression
    push(32'h40); ex_rd = 5'd0; tick();
    chk("x0_rw", 128'(mem_reg_write), 128'd0);
    mem_ready = 1'b1;
    push(32'h41); ex_rd = 5'd5; tick();
    chk("x5_rw", 128'(mem_reg_write), 128'd1);
    chk("x5_rd", 128'(mem_rd), 128'd5);
    ex_valid = 1'b0; tick();

    // Mixed traffic, model-checked
    for (int i = 0; i < 60; i++) begin
      push($urandom);
      ex_valid  = $urandom_range(0, 1);
      mem_ready = $urandom_range(0, 2) != 0;
      flush     = $urandom_range(0, 9) == 0;
      tick();
    end
    flush = 1'b0; ex_valid = 1'b0; mem_ready = 1'b1;
    repeat (3) tick();

`ifdef EXMEM_STAT_EN
    rst_n = 1'b0; tick();
    rst_n = 1'b1; mem_ready = 1'b0;
    push(32'h77); tick();
    ex_valid = 1'b0;
    repeat (4) tick();
    chk("stat_stall4", 128'(stat_stall_cnt), 128'd4);
    flush = 1'b1; mem_ready = 1'b1; tick();
    chk("stat_stall_after", 128'(stat_stall_cnt), 128'd4);
    chk("stat_flush1", 128'(stat_flush_cnt), 128'd1);
    tick();
    chk("stat_flush_idle", 128'(stat_flush_cnt), 128'd1);
    flush = 1'b0; tick();
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
